// File: rtl/ring_buffer.sv
// Circular FIFO with wrap-around read/write pointers.
// Valid/ready on both sides, show-ahead read data, sticky error flags.
module ring_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              clr;

    // Handshake decode and status flags from registered state
    always_comb begin
        full     = (count == FULLC);
        empty    = (count == '0);
        wr_ready = !full;
        rd_valid = !empty;
        clr      = rst_n || flush;
        push     = wr_valid && wr_ready && !clr;
        pop      = rd_valid && rd_ready && !clr;
        rd_data  = mem[rd_ptr];
    end

    // Storage write; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (rd_ready && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ring_buffer.md
Name: ring_buffer

Overview:
Circular FIFO built around a pair of wrap-around pointers: the write pointer advances on each accepted push and the read pointer on each accepted pop. Both wrap DEPTH-1 -> 0, so the block is the storage stage that consumes ring-counter style pointer advance. It has a valid/ready handshake on both sides, show-ahead read data, an occupancy count, and full/empty flags. Sits between a producer and a consumer in the buffer datapath.

Parameters:
DEPTH, 8, number of entries; any integer >= 2 (power of two not required)
DATA_W, 8, width of each stored word in bits

Ports:
clk  input  1  rising-edge clock; all state changes on posedge clk
rst_n  input  1  synchronous reset, active-high (asserted = 1) despite the _n suffix
flush  input  1  synchronous clear of contents; priority below rst_n, above push/pop
wr_valid  input  1  producer presents wr_data
wr_ready  output  1  buffer can accept a word; equals !full
wr_data  input  DATA_W  word to store
rd_valid  output  1  rd_data holds the oldest word; equals !empty
rd_ready  input  1  consumer takes rd_data this cycle
rd_data  output  DATA_W  oldest stored word (show-ahead, combinational from storage)
count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: wr_valid seen while full
underflow  output  1  sticky: rd_ready seen while empty

Behaviour:
- push = wr_valid & wr_ready; pop = rd_valid & rd_ready; both are evaluated on current-cycle registered state.
- State: wr_ptr, rd_ptr (each 0..DEPTH-1), count register, storage array mem[DEPTH], overflow and underflow flags.
- Reset (rst_n=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Outputs: empty=1, full=0, wr_ready=1, rd_valid=0. mem is not cleared; rd_data is don't-care while rd_valid=0.
- flush=1 (rst_n=0): same as reset for the pointers and count; overflow and underflow are also cleared. Push/pop in the same cycle are ignored.
- Push: mem[wr_ptr] <= wr_data. wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- Pop: rd_ptr <= (rd_ptr==DEPTH-1) ? 0 : rd_ptr+1.
- count update: push only -> +1; pop only -> -1; both or neither -> unchanged.
- Latency: a word pushed at edge N is visible on rd_data with rd_valid=1 after edge N. There is no same-cycle empty bypass.
- rd_data = mem[rd_ptr] combinationally. It must not change while rd_valid=1 and no pop occurs.
- Full: wr_ready=0, so no push. A pop is still allowed; the next cycle count=DEPTH-1 and wr_ready=1. wr_valid=1 while full sets overflow; stored data is unaffected.
- Empty: rd_valid=0, so no pop. A push is allowed. rd_ready=1 while empty sets underflow.
- Simultaneous push and pop at a 0 < count < DEPTH: both pointers advance, count holds. This is legal in the same cycle the pointers wrap.
- The sticky flags stay set until rst_n or flush.
- Pointer and count arithmetic uses explicit widths, with no truncation at DEPTH. count must hold the value DEPTH (hence the +1 bit).
- Reset or flush mid-stream: the next cycle shows an empty buffer. Any in-flight handshake is discarded.

Test Plan:
- Reset then idle (DEPTH=8, DATA_W=8): after rst_n pulse -> count=0, empty=1, full=0, wr_ready=1, rd_valid=0, overflow=0, underflow=0.
- Fill: push 0x10..0x17 on 8 consecutive cycles -> count steps 1..8, full=1 and wr_ready=0 after the 8th push. A 9th wr_valid=1 with 0xFF sets overflow=1, and 0xFF is never read out.
- Drain: pop 8 times from full -> rd_data sequence 0x10..0x17 in order, then empty=1. An extra rd_ready=1 sets underflow=1 and count stays 0.
- Wrap with simultaneous push/pop: push 5 words, pop 3, then do 10 cycles of push+pop with incrementing data -> count stays 2 throughout, both pointers wrap 7->0, and the read order exactly matches the write order.
- Full + pop + push: at count=8 assert rd_ready and wr_valid together -> pop only, count=7. The next cycle push succeeds and count=8.
- Flush mid-stream: with count=5 and overflow=1, assert flush together with wr_valid and rd_ready -> next cycle count=0, empty=1, overflow=0. The discarded push never appears on rd_data.
